// File: rtl/frame_streamer.sv
// Raster pixel source: reads one WIDTH x HEIGHT frame from a single-port memory and streams it row-major.
// Optional zero bottom border (PAD_ROWS rows) is enabled by defining FRAME_STREAMER_PAD_EN.
module frame_streamer #(
   parameter int WIDTH    = 17,
   parameter int HEIGHT   = 17,
   parameter int ADDR_W   = 10,
   parameter int PAD_ROWS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              stall_i,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_data_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   output logic              done_o,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   localparam int PIXELS = WIDTH * HEIGHT;
   localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ROW_W  = (HEIGHT + PAD_ROWS > 1) ? $clog2(HEIGHT + PAD_ROWS) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
`ifdef FRAME_STREAMER_PAD_EN
   localparam logic [ROW_W-1:0]  FINAL_ROW = ROW_W'(HEIGHT + PAD_ROWS - 1);
`else
   localparam logic [ROW_W-1:0]  FINAL_ROW = ROW_W'(HEIGHT - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_WAIT = 2'd2
`ifdef FRAME_STREAMER_PAD_EN
      ,S_PAD = 2'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              rd_q, rd_d;
   logic              iss_q, iss_d;
   logic              last_q, last_d;
   logic              iss1_q, iss1_d;
   logic              last1_q, last1_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
`ifdef FRAME_STREAMER_PAD_EN
   logic              pad_q, pad_d;
   logic              pad1_q, pad1_d;
   logic              issue_pad;
`endif

   logic              issue_mem;
   logic [ADDR_W-1:0] cur_addr;
   logic [COL_W-1:0]  cur_col;
   logic [ROW_W-1:0]  cur_row;

   // valid_o qualifies data_o in the same cycle; there is no ready, the consumer must take every valid pixel.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      maddr_d   = maddr_q;
      col_d     = col_q;
      row_d     = row_q;
      busy_d    = busy_q;
      rd_d      = 1'b0;
      iss_d     = 1'b0;
      last_d    = 1'b0;
      cur_addr  = addr_q;
      cur_col   = col_q;
      cur_row   = row_q;
      issue_mem = 1'b0;
`ifdef FRAME_STREAMER_PAD_EN
      issue_pad = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_READ;
               busy_d    = 1'b1;
               cur_addr  = '0;
               cur_col   = '0;
               cur_row   = '0;
               addr_d    = '0;
               col_d     = '0;
               row_d     = '0;
               issue_mem = !stall_i;
            end
         end
         S_READ: issue_mem = !stall_i;
`ifdef FRAME_STREAMER_PAD_EN
         S_PAD:  issue_pad = !stall_i;
`endif
         S_WAIT: begin
            if (done_q) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Column/row track every emitted pixel, memory or pad, so the final-pixel flag covers both.
`ifdef FRAME_STREAMER_PAD_EN
      if (issue_mem || issue_pad) begin
`else
      if (issue_mem) begin
`endif
         iss_d  = 1'b1;
         last_d = (cur_row == FINAL_ROW) && (cur_col == LAST_COL);
         if (cur_col == LAST_COL) begin
            col_d = '0;
            row_d = cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
         end
      end

      if (issue_mem) begin
         rd_d    = 1'b1;
         maddr_d = cur_addr;
         addr_d  = cur_addr + 1'b1;
         if (cur_addr == LAST_ADDR) begin
`ifdef FRAME_STREAMER_PAD_EN
            state_d = (PAD_ROWS > 0) ? S_PAD : S_WAIT;
`else
            state_d = S_WAIT;
`endif
         end
      end
`ifdef FRAME_STREAMER_PAD_EN
      if (issue_pad && last_d) state_d = S_WAIT;
      pad_d  = issue_pad;
      pad1_d = pad_q;
`endif

      iss1_d  = iss_q;
      last1_d = last_q;
      valid_d = iss1_q;
      done_d  = last1_q;
`ifdef FRAME_STREAMER_PAD_EN
      data_d  = (iss1_q && !pad1_q) ? mem_data_i : 8'h00;
`else
      data_d  = iss1_q ? mem_data_i : 8'h00;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         maddr_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         rd_q    <= 1'b0;
         iss_q   <= 1'b0;
         last_q  <= 1'b0;
         iss1_q  <= 1'b0;
         last1_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef FRAME_STREAMER_PAD_EN
         pad_q   <= 1'b0;
         pad1_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         maddr_q <= maddr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         rd_q    <= rd_d;
         iss_q   <= iss_d;
         last_q  <= last_d;
         iss1_q  <= iss1_d;
         last1_q <= last1_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef FRAME_STREAMER_PAD_EN
         pad_q   <= pad_d;
         pad1_q  <= pad1_d;
`endif
      end
   end

   assign mem_rd_o   = rd_q;
   assign mem_addr_o = maddr_q;
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: small 4x3 instance for timing/stall/reset scenarios, default 17x17 instance for full size.
// Expected streams come from a reference model built from the stall pattern and memory image.
module tb_frame_streamer;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 10;
   localparam int PR = 2;
   localparam int N  = W * H;
   localparam int BN = 17 * 17;
`ifdef FRAME_STREAMER_PAD_EN
   localparam int NP  = W * PR;
   localparam int BNP = 17 * 6;
`else
   localparam int NP  = 0;
   localparam int BNP = 0;
`endif
   localparam int T       = N + NP;
   localparam int PAT_LEN = 512;

   logic          clk, rst;
   logic          start_i, stall_i, mem_rd, valid, done, busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data, data;
   logic [1:0]    state;
   logic          b_start, b_stall, b_mem_rd, b_valid, b_done, b_busy;
   logic [9:0]    b_mem_addr;
   logic [7:0]    b_mem_data, b_data;
   logic [1:0]    b_state;

   logic [7:0] mem     [0:1023];
   logic [7:0] big_mem [0:1023];

   int n_cmp = 0;
   int n_err = 0;

   bit stall_pat [0:PAT_LEN-1];
   bit start_pat [0:PAT_LEN-1];

   logic [7:0] got_q[$];
   int         got_cyc[$];
   int         rd_cyc[$];
   int         rd_addr[$];
   int         done_cnt, done_cyc, done_pix, busy_fall;
   bit         timed_out;

   logic [7:0] exp_q[$];
   int         exp_cyc[$];
   int         exp_rd_cyc[$];
   int         exp_done_cyc, exp_busy_fall;

   frame_streamer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PAD_ROWS(PR)) u_dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stall_i(stall_i),
      .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .data_o(data), .valid_o(valid), .done_o(done), .busy_o(busy), .state_o(state)
   );

   frame_streamer u_big (
      .clk(clk), .rst(rst), .start_i(b_start), .stall_i(b_stall),
      .mem_rd_o(b_mem_rd), .mem_addr_o(b_mem_addr), .mem_data_i(b_mem_data),
      .data_o(b_data), .valid_o(b_valid), .done_o(b_done), .busy_o(b_busy), .state_o(b_state)
   );

   // clock / reset block and synchronous memory models
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
      if (b_mem_rd) b_mem_data <= big_mem[b_mem_addr];
   end

   // driver tasks
   task automatic clear_pats();
      for (int e = 0; e < PAT_LEN; e++) begin
         stall_pat[e] = 1'b0;
         start_pat[e] = 1'b0;
      end
   endtask

   task automatic drive_frame(input int budget);
      int c;
      bit seen_done;
      got_q.delete(); got_cyc.delete(); rd_cyc.delete(); rd_addr.delete();
      done_cnt = 0; done_cyc = -1; done_pix = -1; busy_fall = -1;
      timed_out = 1'b0; seen_done = 1'b0; c = 0;
      while (1) begin
         @(negedge clk);
         start_i = (c == 0) ? 1'b1 : start_pat[c];
         stall_i = stall_pat[c];
         @(posedge clk); #1;
         if (mem_rd) begin rd_cyc.push_back(c); rd_addr.push_back(int'(mem_addr)); end
         if (valid) begin got_q.push_back(data); got_cyc.push_back(c); end
         if (done) begin done_cnt++; done_cyc = c; done_pix = got_q.size(); seen_done = 1'b1; end
         if (seen_done && !busy) begin busy_fall = c; break; end
         c++;
         if (c >= budget) begin timed_out = 1'b1; break; end
      end
      @(negedge clk);
      start_i = 1'b0;
      stall_i = 1'b0;
   endtask

   // reference model: a read is issued on every unstalled edge from the accept edge on,
   // each issued pixel shows on valid_o two edges later, pad pixels follow as zeros
   task automatic build_model();
      int k, e;
      exp_q.delete(); exp_cyc.delete(); exp_rd_cyc.delete();
      k = 0; e = 0;
      while (k < T && e < PAT_LEN) begin
         if (!stall_pat[e]) begin
            if (k < N) begin
               exp_rd_cyc.push_back(e);
               exp_q.push_back(mem[k]);
            end else begin
               exp_q.push_back(8'h00);
            end
            exp_cyc.push_back(e + 2);
            k++;
         end
         e++;
      end
      exp_done_cyc  = exp_cyc[exp_cyc.size()-1];
      exp_busy_fall = exp_done_cyc + 1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_rd, mem_addr, data, valid, done, busy, state} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got rd=%0b addr=%0d data=%0d valid=%0b done=%0b busy=%0b state=%0d, expected all 0",
                  mem_rd, mem_addr, data, valid, done, busy, state);
      end
      n_cmp++;
      if ({b_mem_rd, b_mem_addr, b_data, b_valid, b_done, b_busy, b_state} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs_big: got nonzero outputs, expected all 0");
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({valid, busy, mem_rd} !== 3'b000) begin
         n_err++;
         $display("FAIL idle_after_reset: got valid=%0b busy=%0b rd=%0b, expected 0 0 0", valid, busy, mem_rd);
      end
   endtask

   task automatic test_stream();
      clear_pats();
      for (int a = 0; a < N; a++) mem[a] = 8'(a + 1);
      build_model();
      drive_frame(200);
      n_cmp++;
      if (timed_out) begin n_err++; $display("FAIL stream_timeout: got no end of frame within 200 cycles, expected done"); end
      n_cmp++;
      if (got_q.size() != T) begin n_err++; $display("FAIL stream_count: got %0d pixels, expected %0d", got_q.size(), T); end
      for (int i = 0; i < T && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            n_err++;
            $display("FAIL stream_pixel[%0d]: got %0d at edge %0d, expected %0d at edge %0d",
                     i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      n_cmp++;
      if (got_cyc.size() > 0 && got_cyc[0] != 2) begin
         n_err++; $display("FAIL stream_latency: got first pixel at edge %0d, expected 2", got_cyc[0]);
      end
      n_cmp++;
      if (rd_addr.size() != N) begin n_err++; $display("FAIL stream_reads: got %0d reads, expected %0d", rd_addr.size(), N); end
      for (int i = 0; i < N && i < rd_addr.size(); i++) begin
         n_cmp++;
         if (rd_addr[i] != i || rd_cyc[i] != exp_rd_cyc[i]) begin
            n_err++;
            $display("FAIL stream_read[%0d]: got addr %0d at edge %0d, expected addr %0d at edge %0d",
                     i, rd_addr[i], rd_cyc[i], i, exp_rd_cyc[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || done_pix != T || done_cyc != exp_done_cyc) begin
         n_err++;
         $display("FAIL stream_done: got %0d pulses at pixel %0d edge %0d, expected 1 at pixel %0d edge %0d",
                  done_cnt, done_pix, done_cyc, T, exp_done_cyc);
      end
      n_cmp++;
      if (busy_fall != exp_busy_fall) begin
         n_err++; $display("FAIL stream_busy_fall: got edge %0d, expected %0d", busy_fall, exp_busy_fall);
      end
   endtask

   task automatic test_stall();
      for (int it = 0; it < 6; it++) begin
         clear_pats();
         if (it == 0) begin
            for (int a = 0; a < N; a++) mem[a] = 8'(a + 1);
            stall_pat[6] = 1'b1; stall_pat[7] = 1'b1; stall_pat[8] = 1'b1;
         end else begin
            for (int a = 0; a < N; a++) mem[a] = 8'($urandom_range(0, 255));
            for (int e = 1; e < PAT_LEN; e++) stall_pat[e] = ($urandom_range(0, 3) == 0);
         end
         build_model();
         drive_frame(300);
         n_cmp++;
         if (timed_out || got_q.size() != T || rd_addr.size() != N) begin
            n_err++;
            $display("FAIL stall_counts[%0d]: got timeout=%0b pixels=%0d reads=%0d, expected 0 %0d %0d",
                     it, timed_out, got_q.size(), rd_addr.size(), T, N);
         end
         for (int i = 0; i < T && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
               n_err++;
               $display("FAIL stall_pixel[%0d][%0d]: got %0d at edge %0d, expected %0d at edge %0d",
                        it, i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
            end
         end
         for (int i = 0; i < N && i < rd_addr.size(); i++) begin
            n_cmp++;
            if (rd_addr[i] != i || rd_cyc[i] != exp_rd_cyc[i]) begin
               n_err++;
               $display("FAIL stall_read[%0d][%0d]: got addr %0d at edge %0d, expected addr %0d at edge %0d",
                        it, i, rd_addr[i], rd_cyc[i], i, exp_rd_cyc[i]);
            end
         end
         n_cmp++;
         if (done_cnt != 1 || done_cyc != exp_done_cyc || busy_fall != exp_busy_fall) begin
            n_err++;
            $display("FAIL stall_done[%0d]: got %0d pulses at edge %0d busy fall %0d, expected 1 at %0d fall %0d",
                     it, done_cnt, done_cyc, busy_fall, exp_done_cyc, exp_busy_fall);
         end
         if (it == 0 && got_cyc.size() > 6) begin
            n_cmp++;
            if (got_cyc[6] - got_cyc[5] != 4) begin
               n_err++; $display("FAIL stall_gap: got spacing %0d after pixel 6, expected 4", got_cyc[6] - got_cyc[5]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int p, l, dcnt;
      int d_edges[$];
      clear_pats();
      for (int a = 0; a < N; a++) mem[a] = 8'(a + 1);
      start_pat[3] = 1'b1; start_pat[7] = 1'b1; start_pat[N] = 1'b1;
      build_model();
      drive_frame(200);
      n_cmp++;
      if (got_q.size() != T || rd_addr.size() != N || done_cnt != 1) begin
         n_err++;
         $display("FAIL busy_start_ignored: got pixels=%0d reads=%0d done=%0d, expected %0d %0d 1",
                  got_q.size(), rd_addr.size(), done_cnt, T, N);
      end
      for (int i = 0; i < N && i < rd_addr.size(); i++) begin
         n_cmp++;
         if (rd_addr[i] != i) begin
            n_err++; $display("FAIL busy_start_addr[%0d]: got %0d, expected %0d", i, rd_addr[i], i);
         end
      end
      // start held high: one frame every T+3 edges
      p = T + 3;
      l = 3 * p;
      got_q.delete(); got_cyc.delete();
      dcnt = 0;
      for (int c = 0; c < l; c++) begin
         @(negedge clk);
         start_i = 1'b1;
         stall_i = 1'b0;
         @(posedge clk); #1;
         if (valid) begin got_q.push_back(data); got_cyc.push_back(c); end
         if (done) begin dcnt++; d_edges.push_back(c); end
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: got busy=%0b after start dropped, expected 0", busy); end
      n_cmp++;
      if (got_q.size() != 3 * T || dcnt != 3) begin
         n_err++; $display("FAIL b2b_counts: got pixels=%0d done=%0d, expected %0d 3", got_q.size(), dcnt, 3 * T);
      end
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < T; k++) begin
            if (f * T + k < got_q.size()) begin
               n_cmp++;
               if (got_q[f*T+k] !== ((k < N) ? mem[k] : 8'h00) || got_cyc[f*T+k] != f * p + 2 + k) begin
                  n_err++;
                  $display("FAIL b2b_pixel[%0d][%0d]: got %0d at edge %0d, expected %0d at edge %0d",
                           f, k, got_q[f*T+k], got_cyc[f*T+k], (k < N) ? mem[k] : 8'h00, f * p + 2 + k);
               end
            end
         end
         if (f < d_edges.size()) begin
            n_cmp++;
            if (d_edges[f] != f * p + T + 1) begin
               n_err++; $display("FAIL b2b_done[%0d]: got edge %0d, expected %0d", f, d_edges[f], f * p + T + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int cnt, c;
      bit seen_done;
      clear_pats();
      for (int a = 0; a < N; a++) mem[a] = 8'(a + 1);
      cnt = 0; c = 0; seen_done = 1'b0;
      while (cnt < 7 && c < 100) begin
         @(negedge clk);
         start_i = (c == 0);
         stall_i = 1'b0;
         @(posedge clk); #1;
         if (valid) cnt++;
         if (done) seen_done = 1'b1;
         c++;
      end
      n_cmp++;
      if (cnt != 7) begin n_err++; $display("FAIL abort_reach: got %0d pixels, expected 7", cnt); end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({valid, data, mem_rd, mem_addr} !== '0) begin
         n_err++;
         $display("FAIL abort_async_data: got valid=%0b data=%0d rd=%0b addr=%0d, expected 0", valid, data, mem_rd, mem_addr);
      end
      n_cmp++;
      if ({done, busy, state} !== 4'b0000) begin
         n_err++; $display("FAIL abort_async_ctrl: got done=%0b busy=%0b state=%0d, expected 0", done, busy, state);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      n_cmp++;
      if (seen_done) begin n_err++; $display("FAIL abort_no_done: got done pulse for aborted frame, expected none"); end
      build_model();
      drive_frame(200);
      n_cmp++;
      if (got_q.size() != T || done_cnt != 1) begin
         n_err++; $display("FAIL restart_counts: got pixels=%0d done=%0d, expected %0d 1", got_q.size(), done_cnt, T);
      end
      n_cmp++;
      if (got_q.size() == 0 || got_q[0] !== 8'd1 || rd_addr.size() == 0 || rd_addr[0] != 0) begin
         n_err++; $display("FAIL restart_first: got first pixel/address not 1 / 0, expected data 1 at address 0");
      end
      for (int i = 0; i < T && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL restart_pixel[%0d]: got %0d, expected %0d", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_big();
      logic [7:0] bexp_q[$];
      logic [7:0] bgot_q[$];
      int c, rd_n, last_addr, dcnt;
      bit seen_done, tout;
      for (int a = 0; a < BN; a++) begin
         big_mem[a] = 8'($urandom_range(0, 255));
         bexp_q.push_back(big_mem[a]);
      end
      for (int a = 0; a < BNP; a++) bexp_q.push_back(8'h00);
      c = 0; rd_n = 0; last_addr = -1; dcnt = 0; seen_done = 1'b0; tout = 1'b0;
      while (1) begin
         @(negedge clk);
         b_start = (c == 0);
         b_stall = 1'b0;
         @(posedge clk); #1;
         if (b_mem_rd) begin rd_n++; last_addr = int'(b_mem_addr); end
         if (b_valid) bgot_q.push_back(b_data);
         if (b_done) begin dcnt++; seen_done = 1'b1; end
         if (seen_done && !b_busy) break;
         c++;
         if (c >= 1000) begin tout = 1'b1; break; end
      end
      n_cmp++;
      if (tout) begin n_err++; $display("FAIL big_timeout: got no end of frame in 1000 cycles, expected done"); end
      n_cmp++;
      if (bgot_q.size() != BN + BNP) begin
         n_err++; $display("FAIL big_count: got %0d pixels, expected %0d", bgot_q.size(), BN + BNP);
      end
      for (int i = 0; i < bgot_q.size() && i < bexp_q.size(); i++) begin
         n_cmp++;
         if (bgot_q[i] !== bexp_q[i]) begin
            n_err++; $display("FAIL big_pixel[%0d]: got %0d, expected %0d", i, bgot_q[i], bexp_q[i]);
         end
      end
      n_cmp++;
      if (last_addr != BN - 1 || rd_n != BN) begin
         n_err++; $display("FAIL big_reads: got %0d reads last addr %0d, expected %0d last %0d", rd_n, last_addr, BN, BN - 1);
      end
      n_cmp++;
      if (dcnt != 1) begin n_err++; $display("FAIL big_done: got %0d pulses, expected 1", dcnt); end
   endtask

   initial begin
      rst      = 1'b0;
      start_i  = 1'b0;
      stall_i  = 1'b0;
      b_start  = 1'b0;
      b_stall  = 1'b0;
      mem_data   = 8'h00;
      b_mem_data = 8'h00;
      for (int a = 0; a < 1024; a++) begin
         mem[a]     = 8'h00;
         big_mem[a] = 8'h00;
      end
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_big();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Raster pixel source that feeds the 12-row line-buffer chain: reads one frame from a single-port pixel memory and emits a row-major stream on `data_o`/`valid_o`.
- Emits a single-cycle `done_o` on the final pixel. That pulse is what the line-buffer chain latches to drive its flush.
- Sits between the frame memory and the buffer/window stage; started by the controller via `start_i`.

Parameters:
- WIDTH, 17, pixels per row; must equal the downstream line-buffer DEPTH.
- HEIGHT, 17, rows per frame.
- ADDR_W, 10, memory address width; requires WIDTH*HEIGHT <= 2^ADDR_W.
- PAD_ROWS, 6, zero rows appended after the frame; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  frame start request; sampled only in IDLE.
- stall_i  in  1  memory arbitration hold; suppresses issue of new reads.
- mem_rd_o  out  1  memory read strobe.
- mem_addr_o  out  ADDR_W  linear read address.
- mem_data_i  in  8  read data, valid the cycle after mem_rd_o.
- data_o  out  8  pixel out.
- valid_o  out  1  data_o qualifier.
- done_o  out  1  one-cycle pulse, coincident with the final valid_o.
- busy_o  out  1  high from start acceptance until the cycle after done_o.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; address counter, column counter, row counter and read pipeline flags cleared.
- Reset mid-frame: immediate abort. No done_o is produced, and the next frame restarts at address 0.
- FSM states are IDLE, READ, WAIT, PAD (PAD exists only with the optional feature).
- IDLE:
  - start_i=1 at an edge → READ.
  - At that same edge busy_o←1.
  - If stall_i=0, the first read (addr 0) is also issued at that edge.
- READ:
  - Each edge with stall_i=0 and reads remaining: mem_rd_o←1, mem_addr_o←current address, address +1.
  - Edges with stall_i=1: mem_rd_o←0 and the address holds.
  - After the read at address WIDTH*HEIGHT-1 is issued → WAIT.
- Column/row counters:
  - Advance on each issued read; the column wraps at WIDTH-1 to 0 and increments the row.
  - The address is a separate linear counter; no multiply is used.
- Read pipeline:
  - Rd flag delayed one cycle qualifies mem_data_i.
  - data_o←mem_data_i and valid_o←delayed flag, registered.
  - Latency: valid_o is high 2 cycles after the mem_rd_o cycle, so the first pixel appears 2 edges after the start-accept edge.
- Stall: reads already issued still complete and appear on valid_o. valid_o gaps mirror mem_rd_o gaps exactly.
- WAIT:
  - done_o←1 together with valid_o for the last pixel (address WIDTH*HEIGHT-1).
  - Next edge → IDLE, done_o←0, busy_o←0.
  - stall_i is ignored in WAIT.
- start_i:
  - Ignored while busy_o=1.
  - Asserted in the same cycle busy_o falls, it is not accepted; acceptance happens at the following IDLE edge.
- Unstalled frame: exactly WIDTH*HEIGHT consecutive valid_o cycles, and done_o is high exactly once.
- Counter widths: the column counter must hold WIDTH-1 and the row counter HEIGHT+PAD_ROWS-1; the address is ADDR_W bits with no wrap inside a frame.

Optional Feature:
- Macro FRAME_STREAMER_PAD_EN.
- When defined:
  - After the last memory read, the FSM enters PAD instead of WAIT.
  - PAD emits WIDTH*PAD_ROWS pixels of value 0 with valid_o=1, with no memory reads; stall_i still holds pad emission.
  - Pad pixels follow the final memory pixel with no bubble.
  - done_o moves to the last pad pixel, so the downstream window sees a zero bottom border.
- When undefined: no PAD state and no pad logic; done_o is on the last memory pixel.

Test Plan:
1. WIDTH=4, HEIGHT=3, memory[a]=a+1, start pulse, stall_i=0 → mem_rd_o for addr 0..11 on consecutive cycles; data_o 1..12 on 12 consecutive valid cycles starting 2 edges after accept; done_o only with data_o=12; busy_o falls the next cycle.
2. Same config, stall_i=1 for 3 cycles after addr 5 → the address holds at 6; valid_o shows a 3-cycle gap after data_o=6; order 1..12 is preserved; done_o still with 12.
3. start_i held high continuously → frames repeat back-to-back, each with exactly one done_o. start_i pulses during busy_o → ignored, with no address reset.
4. rst driven low at the 7th valid pixel → all outputs 0 asynchronously. After release plus start → the stream restarts at data_o=1, and done_o was not produced for the aborted frame.
5. With FRAME_STREAMER_PAD_EN and PAD_ROWS=2 → 12 memory pixels then 8 zero pixels with no gap; done_o on the 20th valid pixel only; no mem_rd_o during pad.
6. Default WIDTH=17, HEIGHT=17 → 289 valid pixels; last mem_addr_o=288; done_o count=1.
